// File: rtl/chroma_upsampler_pkg.sv
// -----------------------------------------------------------------------------
// chroma_upsampler_pkg
// Shared definitions for the chroma upsampler: subsampling mode encoding,
// sequencer states, channel count and the per-mode last sub-block index.
// -----------------------------------------------------------------------------
package chroma_upsampler_pkg;

   // Channel ids 0 (Y), 1 (Cb), 2 (Cr); the id port is sized to hold CH_NUM.
   localparam int CH_NUM = 3;

   typedef enum logic [1:0] {
      MODE_444  = 2'b00,
      MODE_422  = 2'b01,
      MODE_420  = 2'b10,
      MODE_RSVD = 2'b11
   } mode_e;

   typedef enum logic {
      IDLE = 1'b0,
      EMIT = 1'b1
   } state_e;

   // Index of the final sub-block for a mode (number of output blocks - 1).
   function automatic logic [1:0] last_idx(input mode_e m);
      logic [1:0] r;
      case (m)
         MODE_422: r = 2'd1;
         MODE_420: r = 2'd3;
         default:  r = 2'd0;
      endcase
      return r;
   endfunction

endpackage

// File: rtl/chroma_upsampler_select.sv
// -----------------------------------------------------------------------------
// upsample_select
// Pure sample-replication network: picks the source quadrant/half selected by
// idx and doubles it horizontally (4:2:2) or in both directions (4:2:0).
// Samples are copied bit-exactly.
// Ports:
//   src_i  - captured 8x8 source block
//   mode_i - effective subsampling mode
//   idx_i  - sub-block index (4:2:0 order TL, TR, BL, BR)
//   blk_o  - selected 8x8 output block
// -----------------------------------------------------------------------------
module upsample_select
   import chroma_upsampler_pkg::*;
#(
   parameter int WIDTH = 9
) (
   input  logic [7:0][7:0][WIDTH-1:0] src_i,
   input  mode_e                      mode_i,
   input  logic [1:0]                 idx_i,
   output logic [7:0][7:0][WIDTH-1:0] blk_o
);

   // Replication mux: the source row/column is {idx bit, output coord / 2}.
   always_comb begin
      blk_o = '0;
      for (int i = 0; i < 8; i++) begin
         for (int j = 0; j < 8; j++) begin
            case (mode_i)
               MODE_422: blk_o[i][j] = src_i[3'(i)][{idx_i[0], 2'(j / 2)}];
               MODE_420: blk_o[i][j] = src_i[{idx_i[1], 2'(i / 2)}][{idx_i[0], 2'(j / 2)}];
               default:  blk_o[i][j] = src_i[3'(i)][3'(j)];
            endcase
         end
      end
   end

endmodule

// File: rtl/chroma_upsampler.sv
// -----------------------------------------------------------------------------
// chroma_upsampler
// Accepts one decoded 8x8 block and emits 1, 2 or 4 upsampled 8x8 blocks
// depending on the effective subsampling mode (luma and the reserved mode are
// passed through as 4:4:4).
// Ports:
//   clock, reset           - rising-edge clock, synchronous active-high reset
//   mode, ch               - subsampling mode and channel id of the offered block
//   in_valid/in_ready      - input block handshake (ready only in IDLE)
//   block_in               - 8x8 source block
//   out_valid/out_ready    - output block handshake
//   block_out, out_ch      - upsampled block and its channel id
//   out_idx, out_last      - sub-block index and final-block flag
// -----------------------------------------------------------------------------
module chroma_upsampler
   import chroma_upsampler_pkg::*;
#(
   parameter int WIDTH = 9,
   parameter int CH_W  = $clog2(CH_NUM + 1)
) (
   input  logic                       clock,
   input  logic                       reset,
   input  logic [1:0]                 mode,
   input  logic [CH_W-1:0]            ch,
   input  logic                       in_valid,
   output logic                       in_ready,
   input  logic [7:0][7:0][WIDTH-1:0] block_in,
   output logic                       out_valid,
   input  logic                       out_ready,
   output logic [7:0][7:0][WIDTH-1:0] block_out,
   output logic [CH_W-1:0]            out_ch,
   output logic [1:0]                 out_idx,
   output logic                       out_last
);

   state_e                      state_q, state_d;
   logic [1:0]                  idx_q, idx_d;
   logic [7:0][7:0][WIDTH-1:0]  blk_q, blk_d;
   logic [CH_W-1:0]             ch_q, ch_d;
   mode_e                       mode_q, mode_d;
   mode_e                       eff_mode_s;
   logic [7:0][7:0][WIDTH-1:0]  sel_blk_s;

   // Luma is never subsampled and the reserved code is treated as 4:4:4.
   always_comb begin
      if ((ch == {CH_W{1'b0}}) || (mode == 2'b11)) begin
         eff_mode_s = MODE_444;
      end else begin
         eff_mode_s = mode_e'(mode);
      end
   end

   // Sequencer next state: capture in IDLE, step idx on each output handshake.
   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      blk_d   = blk_q;
      ch_d    = ch_q;
      mode_d  = mode_q;
      case (state_q)
         IDLE: begin
            if (in_valid) begin
               blk_d   = block_in;
               ch_d    = ch;
               mode_d  = eff_mode_s;
               idx_d   = 2'd0;
               state_d = EMIT;
            end else begin
               state_d = IDLE;
            end
         end
         EMIT: begin
            if (out_ready) begin
               if (idx_q == last_idx(mode_q)) begin
                  idx_d   = 2'd0;
                  state_d = IDLE;
               end else begin
                  idx_d   = idx_q + 2'd1;
               end
            end else begin
               idx_d = idx_q;
            end
         end
         default: begin
            state_d = IDLE;
            idx_d   = 2'd0;
         end
      endcase
   end

   // State and capture registers.
   always_ff @(posedge clock) begin
      if (reset) begin
         state_q <= IDLE;
         idx_q   <= 2'd0;
         blk_q   <= '0;
         ch_q    <= {CH_W{1'b0}};
         mode_q  <= MODE_444;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         blk_q   <= blk_d;
         ch_q    <= ch_d;
         mode_q  <= mode_d;
      end
   end

   upsample_select #(
      .WIDTH (WIDTH)
   ) u_select (
      .src_i  (blk_q),
      .mode_i (mode_q),
      .idx_i  (idx_q),
      .blk_o  (sel_blk_s)
   );

   // Output gating: everything reads zero outside EMIT and while in reset.
   always_comb begin
      out_valid = 1'b0;
      block_out = '0;
      out_ch    = {CH_W{1'b0}};
      out_idx   = 2'd0;
      out_last  = 1'b0;
      in_ready  = (!reset) && (state_q == IDLE);
      if ((!reset) && (state_q == EMIT)) begin
         out_valid = 1'b1;
         block_out = sel_blk_s;
         out_ch    = ch_q;
         out_idx   = idx_q;
         out_last  = (idx_q == last_idx(mode_q));
      end else begin
         out_valid = 1'b0;
      end
   end

endmodule

// File: tb/tb_chroma_upsampler.sv
// -----------------------------------------------------------------------------
// tb_chroma_upsampler
// Scoreboard bench: expected output blocks are computed from the source block
// when it is offered and compared against each output handshake.
// -----------------------------------------------------------------------------
module tb_chroma_upsampler;

   localparam int WIDTH = 9;
   localparam int CH_W  = 2;

   typedef logic [7:0][7:0][WIDTH-1:0] blk_t;
   typedef struct packed {
      blk_t       blk;
      logic [1:0] ch;
      logic [1:0] idx;
      logic       last;
   } exp_t;

   logic             clock = 1'b0;
   logic             reset;
   logic [1:0]       mode;
   logic [CH_W-1:0]  ch;
   logic             in_valid;
   logic             in_ready;
   blk_t             block_in;
   logic             out_valid;
   logic             out_ready;
   blk_t             block_out;
   logic [CH_W-1:0]  out_ch;
   logic [1:0]       out_idx;
   logic             out_last;

   exp_t sb_q[$];
   int   hs_cyc_q[$];
   blk_t obs_blk [4];
   int   checks = 0;
   int   errors = 0;
   int   cyc = 0;
   logic rnd_on = 1'b0;

   chroma_upsampler #(.WIDTH(WIDTH), .CH_W(CH_W)) dut (
      .clock     (clock),
      .reset     (reset),
      .mode      (mode),
      .ch        (ch),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .block_in  (block_in),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .block_out (block_out),
      .out_ch    (out_ch),
      .out_idx   (out_idx),
      .out_last  (out_last)
   );

   always #5 clock = ~clock;

   always @(posedge clock) cyc <= cyc + 1;

   task automatic check_val(input string tag, input logic [599:0] obs, input logic [599:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic blk_t ramp_blk();
      blk_t s;
      for (int r = 0; r < 8; r++)
         for (int c = 0; c < 8; c++)
            s[r][c] = 9'(8 * r + c);
      return s;
   endfunction

   function automatic blk_t rnd_blk();
      blk_t s;
      for (int r = 0; r < 8; r++)
         for (int c = 0; c < 8; c++)
            s[r][c] = 9'($urandom_range(0, 511));
      return s;
   endfunction

   // Reference upsampling written directly from the sample formulas.
   function automatic blk_t exp_block(input blk_t s, input int em, input int k);
      blk_t r;
      int   rr, cc;
      for (int i = 0; i < 8; i++) begin
         for (int j = 0; j < 8; j++) begin
            if (em == 1) begin
               rr = i;
               cc = 4 * k + j / 2;
            end else if (em == 2) begin
               rr = 4 * (k / 2) + i / 2;
               cc = 4 * (k % 2) + j / 2;
            end else begin
               rr = i;
               cc = j;
            end
            r[i][j] = s[rr][cc];
         end
      end
      return r;
   endfunction

   // Output monitor: scoreboard compare on handshakes, zero check when idle.
   always @(negedge clock) begin
      if (!reset && out_valid && out_ready) begin
         if (sb_q.size() == 0) begin
            check_val("unexpected_out", 600'(out_valid), 600'(1'b0));
         end else begin
            exp_t e;
            e = sb_q.pop_front();
            check_val("out_blk", 600'(block_out), 600'(e.blk));
            check_val("out_meta", 600'({out_ch, out_idx, out_last}), 600'({e.ch, e.idx, e.last}));
            obs_blk[out_idx] = block_out;
            hs_cyc_q.push_back(cyc);
         end
      end
      if (!out_valid) begin
         check_val("quiet_out", 600'({block_out, out_ch, out_idx, out_last}), 600'(1'b0));
      end
   end

   task automatic send(input logic [1:0] m, input logic [1:0] c, input blk_t src, output int acc_cyc);
      int em, n, waited;
      waited = 0;
      @(negedge clock);
      while (!in_ready && waited < 200) begin
         @(negedge clock);
         waited++;
      end
      if (!in_ready) check_val("in_ready_wait", 600'(in_ready), 600'(1'b1));
      mode     = m;
      ch       = c;
      block_in = src;
      in_valid = 1'b1;
      em = ((c == 2'd0) || (m == 2'd3)) ? 0 : int'(m);
      n  = (em == 0) ? 1 : ((em == 1) ? 2 : 4);
      for (int k = 0; k < n; k++)
         sb_q.push_back('{blk: exp_block(src, em, k), ch: c, idx: 2'(k), last: (k == n - 1)});
      @(posedge clock);
      #1;
      acc_cyc  = cyc;
      in_valid = 1'b0;
      mode     = ~m;
      ch       = 2'(($urandom_range(0, 2)));
      block_in = ~src;
   endtask

   task automatic wait_drain(input string tag);
      int n;
      n = 0;
      while (sb_q.size() != 0 && n < 300) begin
         @(negedge clock);
         #1;
         n++;
      end
      check_val(tag, 600'(sb_q.size()), 600'(0));
   endtask

   initial begin
      int   acc;
      blk_t src, held, ones;
      reset     = 1'b1;
      mode      = 2'b00;
      ch        = 2'd0;
      in_valid  = 1'b0;
      out_ready = 1'b1;
      block_in  = '0;

      // Reset state.
      repeat (3) @(posedge clock);
      @(negedge clock);
      check_val("rst_in_ready", 600'(in_ready), 600'(1'b0));
      check_val("rst_out_valid", 600'({out_valid, out_last}), 600'(1'b0));
      @(posedge clock);
      #1 reset = 1'b0;
      @(negedge clock);
      check_val("post_rst_ready", 600'(in_ready), 600'(1'b1));

      // 4:2:0 Cb ramp: four consecutive blocks, latency one.
      src = ramp_blk();
      hs_cyc_q.delete();
      send(2'b10, 2'd1, src, acc);
      @(negedge clock);
      check_val("c420_in_ready_busy", 600'(in_ready), 600'(1'b0));
      wait_drain("c420_drain");
      check_val("c420_count", 600'(hs_cyc_q.size()), 600'(4));
      if (hs_cyc_q.size() == 4) begin
         check_val("c420_first_cyc", 600'(hs_cyc_q[0]), 600'(acc));
         check_val("c420_last_cyc", 600'(hs_cyc_q[3]), 600'(acc + 3));
      end
      check_val("c420_i2_00", 600'(obs_blk[2][0][0]), 600'(9'd32));
      check_val("c420_i2_77", 600'(obs_blk[2][7][7]), 600'(9'd59));
      while (cyc < acc + 4) @(negedge clock);
      check_val("c420_ready_after", 600'({in_ready, out_valid}), 600'(2'b10));

      // 4:2:2 Cr ramp.
      send(2'b01, 2'd2, src, acc);
      wait_drain("c422_drain");
      check_val("c422_i1_36", 600'(obs_blk[1][3][6]), 600'(9'd31));
      check_val("c422_i1_37", 600'(obs_blk[1][3][7]), 600'(9'd31));

      // Luma with 4:2:0 requested is passed through.
      send(2'b10, 2'd0, src, acc);
      wait_drain("luma_drain");
      check_val("luma_eq", 600'(obs_blk[0]), 600'(src));

      // Backpressure on idx1 of 4:2:0.
      src = rnd_blk();
      send(2'b10, 2'd2, src, acc);
      @(posedge clock);
      #1 out_ready = 1'b0;
      @(negedge clock);
      held = block_out;
      check_val("bp_idx", 600'({out_valid, out_idx}), 600'(3'b101));
      for (int k = 0; k < 2; k++) begin
         @(negedge clock);
         check_val("bp_hold_blk", 600'(block_out), 600'(held));
         check_val("bp_hold_meta", 600'({out_valid, in_ready, out_idx, out_last}), 600'(5'b10010));
      end
      @(posedge clock);
      #1 out_ready = 1'b1;
      wait_drain("bp_drain");

      // Reset after the idx1 handshake of 4:2:0.
      send(2'b10, 2'd1, src, acc);
      @(posedge clock);
      @(posedge clock);
      #1 reset = 1'b1;
      sb_q.delete();
      @(negedge clock);
      check_val("mid_rst_out", 600'({out_valid, out_last, in_ready}), 600'(1'b0));
      @(posedge clock);
      #1 reset = 1'b0;
      @(negedge clock);
      check_val("mid_rst_ready", 600'({in_ready, out_valid}), 600'(2'b10));
      repeat (3) begin
         @(negedge clock);
         check_val("mid_rst_no_idx2", 600'(out_valid), 600'(1'b0));
      end

      // Full-scale samples, reserved mode on chroma.
      for (int r = 0; r < 8; r++)
         for (int c = 0; c < 8; c++)
            ones[r][c] = 9'h1FF;
      send(2'b11, 2'd1, ones, acc);
      wait_drain("wide_drain");
      check_val("wide_eq", 600'(obs_blk[0]), 600'(ones));

      // Random transactions with random output backpressure.
      rnd_on = 1'b1;
      fork
         begin
            for (int t = 0; t < 8; t++) begin
               send(2'($urandom_range(0, 3)), 2'($urandom_range(0, 2)), rnd_blk(), acc);
            end
            rnd_on = 1'b0;
         end
         begin
            while (rnd_on) begin
               @(posedge clock);
               #1 out_ready = 1'($urandom_range(0, 1));
            end
            out_ready = 1'b1;
         end
      join
      wait_drain("rnd_drain");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/chroma_upsampler.md
CHROMA_UPSAMPLER -- requirements
Module: chroma_upsampler

Interface
REQ-001 SHALL have parameter WIDTH, default 9, sample bit width.
REQ-002 SHALL have parameter CH_W, default $clog2(`CH+1), channel-id width.
REQ-003 SHALL have port clock, input, 1, sole clock; all state updates on its rising edge.
REQ-004 SHALL have port reset, input, 1, synchronous active-high reset.
REQ-005 SHALL have port mode, input, 2, subsampling: 00 4:4:4, 01 4:2:2, 10 4:2:0, 11 reserved.
REQ-006 SHALL have port ch, input, CH_W, channel id: 0 Y, 1 Cb, 2 Cr.
REQ-007 SHALL have port in_valid, input, 1, an input block is offered.
REQ-008 SHALL have port in_ready, output, 1, the block accepts an input block.
REQ-009 SHALL have port block_in, input, [7:0][7:0] x WIDTH, decoded 8x8 source block.
REQ-010 SHALL have port out_valid, output, 1, an output block is presented.
REQ-011 SHALL have port out_ready, input, 1, the downstream consumer accepts the output block.
REQ-012 SHALL have port block_out, output, [7:0][7:0] x WIDTH, upsampled 8x8 block.
REQ-013 SHALL have port out_ch, output, CH_W, channel id of the output block.
REQ-014 SHALL have port out_idx, output, 2, sub-block index within the MCU region.
REQ-015 SHALL have port out_last, output, 1, set on the final output block of a source block.

Function
REQ-016 SHALL use states IDLE and EMIT; in_ready = (state==IDLE).
REQ-017 SHALL, on in_valid&&in_ready, register block_in, ch and effective mode, set idx=0, and enter EMIT.
REQ-018 SHALL set effective mode to 4:4:4 when ch==0 or mode==11.
REQ-019 SHALL set output count N = 1 for 4:4:4, 2 for 4:2:2, 4 for 4:2:0.
REQ-020 SHALL assert out_valid in EMIT only, first on the cycle after input acceptance (latency 1).
REQ-021 SHALL hold block_out, out_ch, out_idx and out_last stable while out_valid&&!out_ready.
REQ-022 SHALL increment idx on out_valid&&out_ready, and return to IDLE when idx==N-1.
REQ-023 SHALL drive out_last = out_valid && (idx==N-1).
REQ-024 SHALL compute 4:4:4 output as out[i][j]=src[i][j].
REQ-025 SHALL compute 4:2:2 output as out[i][j]=src[i][4*idx+j/2].
REQ-026 SHALL compute 4:2:0 output as out[i][j]=src[4*idx[1]+i/2][4*idx[0]+j/2], idx order TL, TR, BL, BR.
REQ-027 SHALL copy samples bit-exactly, with no arithmetic, rounding or width change.
REQ-028 SHALL drive block_out, out_ch and out_idx to zero when out_valid==0.
REQ-029 SHALL not accept input in EMIT; no input is accepted in the same cycle as the final output handshake, and the earliest next acceptance is the following cycle.
REQ-030 SHALL ignore changes to mode and ch after acceptance.

Reset
REQ-031 SHALL, on reset, force state to IDLE, idx to 0, and the captured block, ch and mode to 0.
REQ-032 SHALL, while reset is asserted, drive out_valid=0, out_last=0, in_ready=0 and all output data zero.
REQ-033 SHALL, on reset mid-EMIT, discard remaining sub-blocks with no further out_valid.
REQ-034 SHALL assert in_ready=1 on the first cycle after reset deasserts.

Structure
REQ-035 SHALL place the subsampling mode enum (MODE_444, MODE_422, MODE_420, MODE_RSVD) and the state enum in a shared package in sys_defs.svh.
REQ-036 SHALL implement REQ-024..026 in one combinational sub-module, upsample_select (inputs: captured block, mode, idx; output: 8x8 block), instantiated once.
REQ-037 SHALL keep the EMIT sequencing and the handshake logic in chroma_upsampler.

Verification
REQ-038 SHALL verify 4:2:0 Cb: with src[r][c]=8r+c and out_ready=1, four blocks arrive on consecutive cycles; idx2 out[0][0]=32, out[7][7]=59; out_last only on idx3.
REQ-039 SHALL verify 4:2:2 Cr: with src[r][c]=8r+c, two blocks arrive; idx1 out[3][6]=31, out[3][7]=31; out_last on idx1.
REQ-040 SHALL verify luma with mode=10, ch=0: one block identical to src, out_idx=0, out_last=1.
REQ-041 SHALL verify backpressure: with out_ready low 3 cycles during idx1 of 4:2:0, outputs are held unchanged, in_ready stays 0, and idx1 is emitted once.
REQ-042 SHALL verify reset after the idx1 handshake of 4:2:0: out_valid drops, no idx2 appears, and in_ready=1 one cycle after reset release.
REQ-043 SHALL verify sample width: with WIDTH=9, src=9'h1FF in all positions, mode=11, ch=1, one 4:4:4 block of all 9'h1FF is produced.
